// File: rtl/riscv_xc_init_ctrl.sv
// riscv_xc_init_ctrl
// Sequencer that zeroes the XCrypto register bank on xc.init, one register
// per cycle, through register-file write port B. The core's own port-B
// writer always wins the port; a clear write simply slips by one cycle
// whenever the core is writing. The xc.init instruction is held in EX
// while the bank is being cleared, and a one-cycle done pulse follows
// the last clear write.

module riscv_xc_init_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_XC_WORDS = 16,
    parameter int unsigned XC_BASE      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req_i,
    input  logic                  kill_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_b_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_b_i,
    input  logic                  core_we_b_i,
    output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_b_o,
    output logic                  rf_we_b_o,
    output logic                  init_busy_o,
    output logic                  init_done_o,
    output logic                  stall_o
);

    localparam int unsigned IDX_W = (NUM_XC_WORDS > 1) ? $clog2(NUM_XC_WORDS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_XC_WORDS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(XC_BASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic             req_q_r;
    logic             busy_r;
    logic             done_r;

    logic             start_s;
    logic             clear_grant_s;
    logic             stall_s;
    logic [ADDR_WIDTH-1:0] clear_addr_s;

    assign start_s       = init_req_i & ~req_q_r;
    assign clear_grant_s = (state_r == ST_CLEAR) & ~core_we_b_i;
    assign clear_addr_s  = BASE_A + {{(ADDR_WIDTH-IDX_W){1'b0}}, idx_r};

    // Sequencer state, clear index, request edge history and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            req_q_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            req_q_r <= init_req_i;
            if (kill_i) begin
                // Flush abandons the sequence silently; cleared registers stay cleared.
                state_r <= ST_IDLE;
                idx_r   <= {IDX_W{1'b0}};
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_s) begin
                            state_r <= ST_CLEAR;
                            idx_r   <= {IDX_W{1'b0}};
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b0;
                        end
                    end
                    ST_CLEAR: begin
                        if (clear_grant_s) begin
                            // Index wraps to zero naturally after the last register.
                            idx_r <= idx_r + IDX_ONE;
                            if (idx_r == IDX_LAST) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_CLEAR;
                                busy_r  <= 1'b1;
                                done_r  <= 1'b0;
                            end
                        end else begin
                            // Core owns the port this cycle; retry the same index.
                            state_r <= ST_CLEAR;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        idx_r   <= {IDX_W{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Write-port B mux: core writer first, clear write only when the port is free.
    always_comb begin
        rf_waddr_b_o = core_waddr_b_i;
        rf_wdata_b_o = core_wdata_b_i;
        rf_we_b_o    = core_we_b_i;
        if (clear_grant_s) begin
            rf_waddr_b_o = clear_addr_s;
            rf_wdata_b_o = {DATA_WIDTH{1'b0}};
            rf_we_b_o    = 1'b1;
        end else begin
            rf_waddr_b_o = core_waddr_b_i;
            rf_wdata_b_o = core_wdata_b_i;
            rf_we_b_o    = core_we_b_i;
        end
    end

    // Pipeline hold: immediately on the starting edge, then for the whole clear.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE:  stall_s = start_s;
            ST_CLEAR: stall_s = 1'b1;
            ST_DONE:  stall_s = 1'b0;
            default:  stall_s = 1'b0;
        endcase
    end

    assign stall_o     = stall_s;
    assign init_busy_o = busy_r;
    assign init_done_o = done_r;

endmodule
